taxi_disp_ctrl: RTL

//   Display page controller for the taxi-fare meter: selects which quantity
//   (distance, time, price) drives the 4-digit display. Debounces the raw page key,

---
 rtl/taxi_pkg.sv | 24 ++
 rtl/taxi_disp_ctrl_if.sv | 26 ++
 rtl/taxi_disp_ctrl_key_debounce.sv | 57 +++++
 rtl/taxi_disp_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/taxi_pkg.sv
// Shared page codes and page-step helper for the taxi-fare meter blocks.
package taxi_pkg;

   localparam logic [1:0] PG_DIST  = 2'd0;
   localparam logic [1:0] PG_TIME  = 2'd1;
   localparam logic [1:0] PG_PRICE = 2'd2;
   localparam int         PG_NUM   = 3;

   typedef enum logic [1:0] {
      PAGE_DIST  = PG_DIST,
      PAGE_TIME  = PG_TIME,
      PAGE_PRICE = PG_PRICE,
      PAGE_ILL   = 2'd3
   } page_e;

   function automatic page_e page_next(input page_e cur);
      case (cur)
         PAGE_DIST:  page_next = PAGE_TIME;
         PAGE_TIME:  page_next = PAGE_PRICE;
         default:    page_next = PAGE_DIST;
      endcase
   endfunction

endpackage

// File: rtl/taxi_disp_ctrl_if.sv
// Display bus between the meter data sources and the page controller.
interface taxi_disp_if;
   logic [15:0] data_1_kilometer;
   logic [3:0]  data_1_point;
   logic [15:0] data_2_time;
   logic [3:0]  data_2_point;
   logic [15:0] data_3_price;
   logic [3:0]  data_3_point;
   logic [15:0] dis_data;
   logic [3:0]  dis_point;
   logic [1:0]  page_sel;

   modport master (
      output data_1_kilometer, data_1_point,
      output data_2_time, data_2_point,
      output data_3_price, data_3_point,
      input  dis_data, dis_point, page_sel
   );

   modport slave (
      input  data_1_kilometer, data_1_point,
      input  data_2_time, data_2_point,
      input  data_3_price, data_3_point,
      output dis_data, dis_point, page_sel
   );
endinterface

// File: rtl/taxi_disp_ctrl_key_debounce.sv
// Key synchroniser + debounce + press strobe for an active-low meter key.
module key_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic sys_clk,
   input  logic sys_reset_n,
   input  logic key_in,
   output logic key_pulse
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             deb;
   logic             armed;
   logic [CNT_W-1:0] cnt;

   // After reset the key must be seen released for a full debounce interval
   // before presses count, so a key held through reset cannot fire.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         sync_p0   <= 1'b1;
         sync_p1   <= 1'b1;
         deb       <= 1'b1;
         armed     <= 1'b0;
         cnt       <= '0;
         key_pulse <= 1'b0;
      end else begin
         sync_p0   <= key_in;
         sync_p1   <= sync_p0;
         key_pulse <= 1'b0;
         if (!armed) begin
            if (!sync_p1) begin
               cnt <= '0;
            end else if (cnt == CNT_MAX) begin
               cnt   <= '0;
               armed <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else if (sync_p1 != deb) begin
            if (cnt == CNT_MAX) begin
               cnt       <= '0;
               deb       <= sync_p1;
               key_pulse <= ~sync_p1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/taxi_disp_ctrl.sv
// Display page controller: key/trip driven page FSM and registered display mux.
// Optional auto page scroll during a trip when TAXI_AUTO_SCROLL_EN is defined.
module taxi_disp_ctrl
   import taxi_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int SCROLL_CYC   = 150_000_000
) (
   input  logic        sys_clk,
   input  logic        sys_reset_n,
   input  logic        key_in,
   input  logic        trip_active,
   taxi_disp_if.slave  disp,
   output logic        key_pulse
);

   page_e       page_q;
   page_e       page_d;
   logic        trip_d;
   logic        trip_rise;
   logic        trip_fall;
   logic        scroll_hit;
   logic        advance;
   logic [15:0] sel_data;
   logic [3:0]  sel_point;
   logic [15:0] dis_data_p1;
   logic [3:0]  dis_point_p1;

   key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_key (
      .sys_clk     (sys_clk),
      .sys_reset_n (sys_reset_n),
      .key_in      (key_in),
      .key_pulse   (key_pulse)
   );

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         trip_d <= 1'b0;
      end else begin
         trip_d <= trip_active;
      end
   end

   assign trip_rise = trip_active & ~trip_d;
   assign trip_fall = ~trip_active & trip_d;

`ifdef TAXI_AUTO_SCROLL_EN
   localparam int SC_W = (SCROLL_CYC > 1) ? $clog2(SCROLL_CYC) : 1;
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCROLL_CYC - 1);

   logic [SC_W-1:0] scroll_cnt;

   assign scroll_hit = trip_active & ~trip_rise & (scroll_cnt == SC_MAX);

   // Any manual or trip-driven page change restarts the full idle interval.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         scroll_cnt <= '0;
      end else if (!trip_active || key_pulse || trip_rise || scroll_hit) begin
         scroll_cnt <= '0;
      end else begin
         scroll_cnt <= scroll_cnt + 1'b1;
      end
   end
`else
   assign scroll_hit = 1'b0;
`endif

   assign advance = key_pulse | scroll_hit;

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         page_q <= PAGE_DIST;
      end else begin
         page_q <= page_d;
      end
   end

   // Trip edges take priority; a key press landing on a trip edge is dropped.
   always_comb begin
      page_d = page_q;
      if (page_q == PAGE_ILL) begin
         page_d = PAGE_DIST;
      end else if (trip_rise) begin
         page_d = PAGE_DIST;
      end else if (trip_fall) begin
         page_d = PAGE_PRICE;
      end else if (advance) begin
         page_d = page_next(page_q);
      end
   end

   always_comb begin
      sel_data  = 16'h0000;
      sel_point = 4'h0;
      case (page_q)
         PAGE_DIST: begin
            sel_data  = disp.data_1_kilometer;
            sel_point = disp.data_1_point;
         end
         PAGE_TIME: begin
            sel_data  = disp.data_2_time;
            sel_point = disp.data_2_point;
         end
         PAGE_PRICE: begin
            sel_data  = disp.data_3_price;
            sel_point = disp.data_3_point;
         end
         default: begin
            sel_data  = 16'h0000;
            sel_point = 4'h0;
         end
      endcase
   end

   // Output register stage towards the segment driver
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         dis_data_p1  <= 16'h0000;
         dis_point_p1 <= 4'h0;
      end else begin
         dis_data_p1  <= sel_data;
         dis_point_p1 <= sel_point;
      end
   end

   assign disp.dis_data  = dis_data_p1;
   assign disp.dis_point = dis_point_p1;
   assign disp.page_sel  = page_q;

endmodule
